tcm_dual_port_mem: RTL and testbench
====================================

// Module: tcm_dual_port_mem
// PURPOSE
//  Tightly-coupled memory behind the RISC-V core: one 64-bit instruction-fetch port and one 32-bit data port.
//  Both ports always accept and respond one cycle after the request; the memory never signals an error.
//  Instantiated beside riscv_core in the SoC and in core benches; the program image is loaded through a simulation backdoor.
// PARAMETERS
//  ADDR_W  14  64-bit word-index bits; capacity = 2**ADDR_W * 8 bytes (default 128 KiB)
// PORTS
//  clk                 in   1   clock; all logic on rising edge
//  rst                 in   1   reset, synchronous, active-low
//  mem_i_rd_i          in   1   fetch request
//  mem_i_flush_i       in   1   fetch flush hint; ignored
//  mem_i_invalidate_i  in   1   fetch invalidate hint; ignored
//  mem_i_pc_i          in   32  fetch byte address
//  mem_i_accept_o      out  1   fetch accepted; constant 1
//  mem_i_valid_o       out  1   fetch data valid
//  mem_i_error_o       out  1   fetch error; constant 0
//  mem_i_inst_o        out  64  fetched 64-bit word (two instructions)
//  mem_d_addr_i        in   32  data byte address
//  mem_d_data_wr_i     in   32  write data
//  mem_d_rd_i          in   1   read request
//  mem_d_wr_i          in   4   byte-write enables; nonzero = write request
//  mem_d_cacheable_i   in   1   ignored
//  mem_d_req_tag_i     in   11  request tag
//  mem_d_invalidate_i  in   1   cache-maintenance request; acked, no effect
//  mem_d_writeback_i   in   1   cache-maintenance request; acked, no effect
//  mem_d_flush_i       in   1   cache-maintenance request; acked, no effect
//  mem_d_data_rd_o     out  32  read data
//  mem_d_accept_o      out  1   request accepted; constant 1
//  mem_d_ack_o         out  1   response strobe
//  mem_d_error_o       out  1   data error; constant 0
//  mem_d_resp_tag_o    out  11  tag of the acked request
// BEHAVIOUR
//  - Storage: 2**ADDR_W x 64-bit words, little-endian. Word index = addr[ADDR_W+2:3]; higher address bits are ignored, so 0x8000_0000 aliases word 0.
//  - Fetch: if mem_i_rd_i is high at edge N, then at N+1 mem_i_valid_o=1 and mem_i_inst_o=word[pc index]. Otherwise valid=0. A request is allowed every cycle.
//  - Data request = mem_d_rd_i | (|mem_d_wr_i) | invalidate | writeback | flush.
//  - For a request at edge N: at N+1 mem_d_ack_o=1 and mem_d_resp_tag_o=tag. Otherwise ack=0 and resp_tag holds its last value.
//  - Data read: mem_d_data_rd_o = addr[2] ? word[63:32] : word[31:0], valid with the ack. addr[1:0] are ignored.
//  - Data write: byte enable k writes data_wr[8k+7:8k] into lane addr[2], byte k. The write is visible to any access from edge N+1 onward.
//  - If rd and wr are both asserted, the write occurs and read data returns the pre-write word.
//  - Fetch/data same-word collision in one cycle: fetch returns the pre-write word.
//  - Reset (rst low at an edge): mem_i_valid_o=0, mem_d_ack_o=0, mem_d_resp_tag_o=0, mem_d_data_rd_o=0, mem_i_inst_o=0. RAM contents are preserved.
//  - Requests sampled while rst is low are dropped.
//  - Constant outputs: accept=1 and error=0 at all times, including during reset.
//  - Backdoor (simulation only): task write(input [31:0] byte_addr, input [7:0] data) updates byte byte_addr[2:0] of word byte_addr[ADDR_W+2:3] immediately, with no clock.
// STRUCTURE
//  - Shared package: TCM_TAG_W=11, TCM_INST_W=64, TCM_DATA_W=32.
//  - One sub-module tcm_ram_dp, instance u_ram: true dual-port 64-bit RAM.
//    - Array named ram, indexed by word.
//    - Port A: read-only, fetch.
//    - Port B: read plus 8-bit byte-write, data.
//    - Both ports have registered read data.
//  - Top level: lane select, write-enable expansion (4 to 8 bits by addr[2]), valid/ack/tag registers, and the backdoor task.
// TESTING
//  - Backdoor-load bytes 0..7 = 01..08. After reset, fetch pc 0x8000_0000 -> next cycle valid=1, inst=0x0807060504030201.
//  - Fetch every cycle at 0x..00, 0x..08, 0x..10 -> valid held at 1, correct word each cycle, one-cycle latency.
//  - Data write addr 0x8000_0104, data 0xAABBCCDD, wr=4'b0011, tag 0x155 -> ack next cycle, resp_tag=0x155. Then read the same address -> 0x0000CCDD (prior zero).
//  - Read addr 0x8000_0100 vs 0x8000_0104 after backdoor load -> lower vs upper lane of word 0x20.
//  - flush=1 alone, tag 0x7FF -> ack=1, resp_tag=0x7FF, memory unchanged. No request -> ack=0.
//  - Assert rst low while a fetch is in flight -> valid=0 and ack=0 next cycle. Afterwards a fetch still returns the preloaded data.

Source files
------------

// File: rtl/tcm_dual_port_mem_pkg.sv
// Shared widths and helpers for the tightly-coupled memory.
//   TCM_TAG_W  : data-port request/response tag width
//   TCM_INST_W : fetch word width (also the RAM word width)
//   TCM_DATA_W : data-port word width
package tcm_dual_port_mem_pkg;

  localparam int unsigned TCM_TAG_W  = 11;
  localparam int unsigned TCM_INST_W = 64;
  localparam int unsigned TCM_DATA_W = 32;
  localparam int unsigned TCM_ADDR_W = 14;
  localparam int unsigned TCM_BE_W   = TCM_INST_W / 8;
  localparam int unsigned TCM_DBE_W  = TCM_DATA_W / 8;

  // Steer 4 data-port byte enables onto the lower or upper half of a RAM word.
  function automatic logic [TCM_BE_W-1:0] tcm_lane_be(input logic lane,
                                                      input logic [TCM_DBE_W-1:0] be);
    tcm_lane_be = lane ? {be, {TCM_DBE_W{1'b0}}} : {{TCM_DBE_W{1'b0}}, be};
  endfunction

endpackage

// File: rtl/tcm_dual_port_mem_if.sv
// Core-side bus of the TCM: 64-bit fetch port and 32-bit tagged data port.
//   master : core side (drives requests, receives responses)
//   slave  : memory side
interface tcm_dual_port_mem_if;
  import tcm_dual_port_mem_pkg::*;

  // fetch port
  logic                  mem_i_rd_i;
  logic                  mem_i_flush_i;
  logic                  mem_i_invalidate_i;
  logic [31:0]           mem_i_pc_i;
  logic                  mem_i_accept_o;
  logic                  mem_i_valid_o;
  logic                  mem_i_error_o;
  logic [TCM_INST_W-1:0] mem_i_inst_o;

  // data port
  logic [31:0]           mem_d_addr_i;
  logic [TCM_DATA_W-1:0] mem_d_data_wr_i;
  logic                  mem_d_rd_i;
  logic [TCM_DBE_W-1:0]  mem_d_wr_i;
  logic                  mem_d_cacheable_i;
  logic [TCM_TAG_W-1:0]  mem_d_req_tag_i;
  logic                  mem_d_invalidate_i;
  logic                  mem_d_writeback_i;
  logic                  mem_d_flush_i;
  logic [TCM_DATA_W-1:0] mem_d_data_rd_o;
  logic                  mem_d_accept_o;
  logic                  mem_d_ack_o;
  logic                  mem_d_error_o;
  logic [TCM_TAG_W-1:0]  mem_d_resp_tag_o;

  modport master (
    output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
           mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
    input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
  );

  modport slave (
    input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
           mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
    output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
  );

endinterface

// File: rtl/tcm_ram_dp.sv
// True dual-port 64-bit RAM with registered read data on both ports.
//   clk, rst          : clock, synchronous active-low reset (read regs only, not contents)
//   a_rd, a_addr      : port A read (fetch), a_data registered
//   b_rd, b_addr      : port B read (data), b_rdata registered, read-before-write
//   b_be, b_wdata     : port B byte-write enables / data
module tcm_ram_dp
  import tcm_dual_port_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = TCM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_rd,
  input  logic [ADDR_W-1:0]     a_addr,
  output logic [TCM_INST_W-1:0] a_data,
  input  logic                  b_rd,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [TCM_BE_W-1:0]   b_be,
  input  logic [TCM_INST_W-1:0] b_wdata,
  output logic [TCM_INST_W-1:0] b_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [TCM_INST_W-1:0] ram [DEPTH];

  // Port A registered read; nonblocking write on port B keeps this pre-write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_data <= '0;
    end else if (a_rd) begin
      a_data <= ram[a_addr];
    end
  end

  // Port B registered read, returns the word as it was before this cycle's write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      b_rdata <= '0;
    end else if (b_rd) begin
      b_rdata <= ram[b_addr];
    end
  end

  // Port B byte writes; requests during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(TCM_BE_W); k++) begin
        if (b_be[k]) ram[b_addr][8*k +: 8] <= b_wdata[8*k +: 8];
      end
    end
  end

  // Simulation backdoor: lands within the current time step, no clock needed.
  task automatic backdoor_write(input logic [ADDR_W-1:0] idx,
                                input logic [2:0]        byte_sel,
                                input logic [7:0]        data);
    ram[idx][{byte_sel, 3'b000} +: 8] <= data;
  endtask

endmodule

// File: rtl/tcm_dual_port_mem.sv
// Tightly-coupled memory beside the RISC-V core: 64-bit fetch port, 32-bit data port,
// both answering one cycle after the request, never stalling, never erroring.
//   clk, rst : clock, synchronous active-low reset (RAM contents preserved)
//   bus      : tcm_dual_port_mem_if slave modport (fetch + data ports)
//   write()  : simulation backdoor byte write for program loading
module tcm_dual_port_mem
  import tcm_dual_port_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = TCM_ADDR_W
) (
  input logic                clk,
  input logic                rst,
  tcm_dual_port_mem_if.slave bus
);

  logic [ADDR_W-1:0]     i_idx_c;
  logic [ADDR_W-1:0]     d_idx_c;
  logic [TCM_BE_W-1:0]   be_c;
  logic [TCM_INST_W-1:0] wdata_c;
  logic                  d_req_c;
  logic [TCM_INST_W-1:0] d_word;

  logic                  i_valid_q;
  logic                  d_ack_q;
  logic [TCM_TAG_W-1:0]  d_tag_q;
  logic                  lane_q;

  // Upper address bits alias; hints and cacheable have no effect here.
  logic unused_c;
  assign unused_c = ^{bus.mem_i_pc_i[31:ADDR_W+3], bus.mem_i_pc_i[2:0],
                      bus.mem_d_addr_i[31:ADDR_W+3], bus.mem_d_addr_i[1:0],
                      bus.mem_i_flush_i, bus.mem_i_invalidate_i, bus.mem_d_cacheable_i};

  assign i_idx_c = bus.mem_i_pc_i[ADDR_W+2:3];
  assign d_idx_c = bus.mem_d_addr_i[ADDR_W+2:3];
  assign be_c    = tcm_lane_be(bus.mem_d_addr_i[2], bus.mem_d_wr_i);
  assign wdata_c = {2{bus.mem_d_data_wr_i}};

  // Cache-maintenance ops are acknowledged like any other request.
  assign d_req_c = bus.mem_d_rd_i | (|bus.mem_d_wr_i) | bus.mem_d_invalidate_i
                 | bus.mem_d_writeback_i | bus.mem_d_flush_i;

  tcm_ram_dp #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_rd    (bus.mem_i_rd_i),
    .a_addr  (i_idx_c),
    .a_data  (bus.mem_i_inst_o),
    .b_rd    (bus.mem_d_rd_i),
    .b_addr  (d_idx_c),
    .b_be    (be_c),
    .b_wdata (wdata_c),
    .b_rdata (d_word)
  );

  // Response strobes, tag and read-lane registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_valid_q <= 1'b0;
      d_ack_q   <= 1'b0;
      d_tag_q   <= '0;
      lane_q    <= 1'b0;
    end else begin
      i_valid_q <= bus.mem_i_rd_i;
      d_ack_q   <= d_req_c;
      if (d_req_c)        d_tag_q <= bus.mem_d_req_tag_i;
      if (bus.mem_d_rd_i) lane_q  <= bus.mem_d_addr_i[2];
    end
  end

  assign bus.mem_i_valid_o    = i_valid_q;
  assign bus.mem_i_accept_o   = 1'b1;
  assign bus.mem_i_error_o    = 1'b0;
  assign bus.mem_d_ack_o      = d_ack_q;
  assign bus.mem_d_resp_tag_o = d_tag_q;
  assign bus.mem_d_accept_o   = 1'b1;
  assign bus.mem_d_error_o    = 1'b0;
  assign bus.mem_d_data_rd_o  = lane_q ? d_word[63:32] : d_word[31:0];

  // Backdoor byte load (simulation only).
  task automatic write(input logic [31:0] byte_addr, input logic [7:0] data);
    u_ram.backdoor_write(byte_addr[ADDR_W+2:3], byte_addr[2:0], data);
  endtask

endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// Self-checking bench for tcm_dual_port_mem: directed cases then randomized traffic
// against a word-array reference model confined to the first 64 words.
module tb_tcm_dual_port_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tcm_dual_port_mem_if bus();

  tcm_dual_port_mem #(.ADDR_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] mdl [64];
  logic [10:0] exp_tag = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
    dut.write(a, d);
    mdl[a[8:3]][{a[2:0], 3'b000} +: 8] = d;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [63:0] w);
    for (int b = 0; b < 8; b++) load_byte({a[31:3], 3'(b)}, w[8*b +: 8]);
  endtask

  // Random address inside the modelled 64 words, random aliasing/ignored bits.
  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[16:9] = '0;
    return a;
  endfunction

  // One clock of stimulus; expectations come from the model as it stood before the edge.
  task automatic cycle(input logic r, input logic f_rd, input logic [31:0] pc,
                       input logic d_rd, input logic [3:0] d_wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [10:0] tag, input logic [2:0] cmo);
    logic [63:0] e_inst;
    logic [63:0] word;
    logic [31:0] e_drd;
    logic        req;
    rst                    = r;
    bus.mem_i_rd_i         = f_rd;
    bus.mem_i_pc_i         = pc;
    bus.mem_i_flush_i      = 1'($urandom);
    bus.mem_i_invalidate_i = 1'($urandom);
    bus.mem_d_cacheable_i  = 1'($urandom);
    bus.mem_d_rd_i         = d_rd;
    bus.mem_d_wr_i         = d_wr;
    bus.mem_d_addr_i       = addr;
    bus.mem_d_data_wr_i    = wdata;
    bus.mem_d_req_tag_i    = tag;
    bus.mem_d_invalidate_i = cmo[0];
    bus.mem_d_writeback_i  = cmo[1];
    bus.mem_d_flush_i      = cmo[2];
    req    = d_rd | (|d_wr) | (|cmo);
    e_inst = mdl[pc[8:3]];
    word   = mdl[addr[8:3]];
    e_drd  = addr[2] ? word[63:32] : word[31:0];
    if (r) begin
      for (int k = 0; k < 4; k++)
        if (d_wr[k]) mdl[addr[8:3]][(addr[2] ? 32 : 0) + 8*k +: 8] = wdata[8*k +: 8];
      if (req) exp_tag = tag;
    end else begin
      exp_tag = '0;
    end
    @(posedge clk);
    #1;
    check("i_valid", 64'(bus.mem_i_valid_o), 64'(r & f_rd));
    check("d_ack", 64'(bus.mem_d_ack_o), 64'(r & req));
    check("resp_tag", 64'(bus.mem_d_resp_tag_o), 64'(exp_tag));
    check("const_outs", 64'({bus.mem_i_accept_o, bus.mem_d_accept_o,
                             bus.mem_i_error_o, bus.mem_d_error_o}), 64'(4'b1100));
    if (!r) begin
      check("rst_inst", bus.mem_i_inst_o, 64'h0);
      check("rst_drd", 64'(bus.mem_d_data_rd_o), 64'h0);
    end else begin
      if (f_rd) check("inst", bus.mem_i_inst_o, e_inst);
      if (d_rd) check("d_rdata", 64'(bus.mem_d_data_rd_o), 64'(e_drd));
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.mem_i_rd_i = 1'b0; bus.mem_i_flush_i = 1'b0; bus.mem_i_invalidate_i = 1'b0;
    bus.mem_i_pc_i = '0;   bus.mem_d_addr_i = '0;   bus.mem_d_data_wr_i = '0;
    bus.mem_d_rd_i = 1'b0; bus.mem_d_wr_i = '0;     bus.mem_d_cacheable_i = 1'b0;
    bus.mem_d_req_tag_i = '0; bus.mem_d_invalidate_i = 1'b0;
    bus.mem_d_writeback_i = 1'b0; bus.mem_d_flush_i = 1'b0;

    for (int w = 0; w < 64; w++) load_word(32'(w) << 3, 64'h0);
    for (int b = 0; b < 8; b++) load_byte(32'(b), 8'(b + 1));
    load_word(32'h0000_0008, {$urandom, $urandom});
    load_word(32'h0000_0010, {$urandom, $urandom});

    // Reset with requests present: everything dropped, outputs cleared.
    cycle(1'b0, 1'b1, 32'h8000_0000, 1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678, 11'h3, 3'b0);
    cycle(1'b0, 1'b1, 32'h8000_0000, 1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678, 11'h3, 3'b0);

    // Boot fetch through aliased address, then back-to-back fetches.
    cycle(1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b0);
    check("boot_word", bus.mem_i_inst_o, 64'h0807_0605_0403_0201);
    cycle(1'b1, 1'b1, 32'h8000_0008, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b0);
    cycle(1'b1, 1'b1, 32'h8000_0010, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b0);

    // Partial write to upper lane of word 0x20, then read it back.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 4'b0011, 32'h8000_0104, 32'hAABB_CCDD, 11'h155, 3'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0104, 32'h0, 11'h0AA, 3'b0);
    check("partial_wr", 64'(bus.mem_d_data_rd_o), 64'h0000_CCDD);

    // Lane select on a backdoor-loaded word.
    load_word(32'h0000_0100, 64'h1122_3344_5566_7788);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h011, 3'b0);
    check("lane_lo", 64'(bus.mem_d_data_rd_o), 64'h5566_7788);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0104, 32'h0, 11'h012, 3'b0);
    check("lane_hi", 64'(bus.mem_d_data_rd_o), 64'h1122_3344);

    // Flush alone is acked, no request drops ack and holds tag.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h8000_0100, 32'hFFFF_FFFF, 11'h7FF, 3'b100);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h001, 3'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h013, 3'b0);

    // Read+write same word, with a fetch of that word in the same cycle.
    cycle(1'b1, 1'b1, 32'h8000_0100, 1'b1, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF, 11'h014, 3'b0);
    check("rw_pre", 64'(bus.mem_d_data_rd_o), 64'h5566_7788);
    check("fetch_pre", bus.mem_i_inst_o, 64'h1122_3344_5566_7788);
    cycle(1'b1, 1'b1, 32'h8000_0100, 1'b1, 4'h0, 32'h8000_0100, 32'h0, 11'h015, 3'b0);
    check("rw_post", 64'(bus.mem_d_data_rd_o), 64'hDEAD_BEEF);

    // Reset lands while a fetch is in flight.
    cycle(1'b1, 1'b1, 32'h8000_0008, 1'b1, 4'h0, 32'h8000_0008, 32'h0, 11'h016, 3'b0);
    cycle(1'b0, 1'b1, 32'h8000_0010, 1'b1, 4'h0, 32'h8000_0010, 32'h0, 11'h017, 3'b0);
    cycle(1'b1, 1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b0);
    check("post_rst_boot", bus.mem_i_inst_o, 64'h0807_0605_0403_0201);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wr;
      logic [2:0] cmo;
      wr  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      cmo = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b0;
      cycle(($urandom_range(0, 39) != 0), 1'($urandom), rnd_addr(), 1'($urandom),
            wr, rnd_addr(), $urandom, 11'($urandom), cmo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
